pst_eval_engine: RTL and testbench

//  Sequential piece-square-table (PST) evaluator for the eval path. Holds one

---
 rtl/pst_eval_engine.sv | 118 +++++++++++
 tb/tb_pst_eval_engine.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pst_eval_engine.sv
// Piece-square-table evaluator: scans a latched 64-square board LANES squares per cycle into a saturating signed score.
// Latency: start in cycle 0 gives done and a valid score in cycle 64/LANES+1. start and wr_en are dropped while busy and are never queued.
module pst_eval_engine #(
   parameter int VAL_W   = 6,
   parameter int SCORE_W = 16,
   parameter int LANES   = 1,
   parameter int NTYPES  = 6
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               start,
   input  logic [255:0]       board,
   input  logic               wr_en,
   input  logic [2:0]         wr_type,
   input  logic [5:0]         wr_sq,
   input  logic [VAL_W-1:0]   wr_data,
   output logic               busy,
   output logic               done,
   output logic [SCORE_W-1:0] score
);

   localparam int GROUPS = 64 / LANES;
   localparam int SUM_W  = SCORE_W + VAL_W + 8;
   localparam int TW     = (NTYPES > 1) ? $clog2(NTYPES) : 1;
   localparam logic signed [SUM_W-1:0] SAT_HI = {{(SUM_W-SCORE_W+1){1'b0}}, {(SCORE_W-1){1'b1}}};
   localparam logic signed [SUM_W-1:0] SAT_LO = {{(SUM_W-SCORE_W+1){1'b1}}, {(SCORE_W-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

   state_t                    state_q, state_d;
   logic signed [VAL_W-1:0]   tbl [NTYPES][64];
   logic [255:0]              board_q;
   logic [5:0]                k;
   logic [SCORE_W-1:0]        acc;
   logic                      last_grp;
   logic [5:0]                sq, idx;
   logic [3:0]                nib;
   logic signed [VAL_W-1:0]   ent;
   logic signed [SUM_W-1:0]   lane_sum, acc_sum, acc_sat;

   assign last_grp = (k == 6'(GROUPS - 1));
   assign busy     = (state_q != IDLE);
   assign done     = (state_q == DONE);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = SCAN;
         SCAN:    if (last_grp) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Black pieces read the rank-mirrored entry and subtract; the lane sum is wide enough never to wrap.
   always_comb begin
      lane_sum = '0;
      sq       = '0;
      idx      = '0;
      nib      = '0;
      ent      = '0;
      for (int l = 0; l < LANES; l++) begin
         sq  = 6'(int'(k) * LANES + l);
         nib = board_q[{sq, 2'b00} +: 4];
         idx = nib[3] ? (sq ^ 6'd56) : sq;
         ent = '0;
         for (int t = 0; t < NTYPES; t++) begin
            if (nib[2:0] == 3'(t + 1)) ent = tbl[TW'(t)][idx];
         end
         if (nib[3]) lane_sum = lane_sum - SUM_W'(ent);
         else        lane_sum = lane_sum + SUM_W'(ent);
      end
      acc_sum = $signed({{(SUM_W-SCORE_W){acc[SCORE_W-1]}}, acc}) + lane_sum;
      if (acc_sum > SAT_HI)      acc_sat = SAT_HI;
      else if (acc_sum < SAT_LO) acc_sat = SAT_LO;
      else                       acc_sat = acc_sum;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         board_q <= '0;
         k       <= '0;
         acc     <= '0;
         score   <= '0;
      end else begin
         case (state_q)
            IDLE: if (start) begin
               board_q <= board;
               k       <= '0;
               acc     <= '0;
            end
            SCAN: begin
               acc <= acc_sat[SCORE_W-1:0];
               k   <= k + 6'd1;
               if (last_grp) score <= acc_sat[SCORE_W-1:0];
            end
            default: ;
         endcase
      end
   end

   // A write in the same IDLE cycle as start lands before the first scan read.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         tbl <= '{default: '0};
      end else if (state_q == IDLE && wr_en) begin
         for (int t = 0; t < NTYPES; t++) begin
            if (wr_type == 3'(t + 1)) tbl[TW'(t)][wr_sq] <= wr_data;
         end
      end
   end

endmodule

// File: tb/tb_pst_eval_engine.sv
// Bench for pst_eval_engine: LANES=1/SCORE_W=16 and LANES=8/SCORE_W=8 instances against a plain-arithmetic model.
module tb_pst_eval_engine;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic               reset_n;
   logic [255:0]       board;
   logic [2:0]         wr_type;
   logic [5:0]         wr_sq;
   logic [5:0]         wr_data;
   logic               start1, wr_en1, busy1, done1;
   logic [15:0]        score1;
   logic               start8, wr_en8, busy8, done8;
   logic [7:0]         score8;

   pst_eval_engine dut1 (
      .clk(clk), .reset_n(reset_n), .start(start1), .board(board),
      .wr_en(wr_en1), .wr_type(wr_type), .wr_sq(wr_sq), .wr_data(wr_data),
      .busy(busy1), .done(done1), .score(score1));

   pst_eval_engine #(.LANES(8), .SCORE_W(8)) dut8 (
      .clk(clk), .reset_n(reset_n), .start(start8), .board(board),
      .wr_en(wr_en8), .wr_type(wr_type), .wr_sq(wr_sq), .wr_data(wr_data),
      .busy(busy8), .done(done8), .score(score8));

   typedef struct {
      logic [255:0] b;
      int           exp;
   } vec_t;

   int   checks = 0;
   int   errors = 0;
   int   tm [2][8][64];
   int   last [2];
   vec_t vt [10];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   function automatic int g_score(input int w);
      return (w != 0) ? int'($signed(score8)) : int'($signed(score1));
   endfunction

   function automatic int g_done(input int w);
      return (w != 0) ? int'(done8) : int'(done1);
   endfunction

   function automatic int g_busy(input int w);
      return (w != 0) ? int'(busy8) : int'(busy1);
   endfunction

   task automatic set_start(input int w, input logic v);
      if (w != 0) start8 = v;
      else        start1 = v;
   endtask

   function automatic logic [255:0] put(input logic [255:0] b, input int s, input logic [3:0] n);
      logic [255:0] r;
      r = b;
      r[4*s +: 4] = n;
      return r;
   endfunction

   function automatic logic [255:0] rand_board();
      logic [255:0] b;
      b = '0;
      for (int s = 0; s < 64; s++)
         if ($urandom_range(0, 2) != 0) b[4*s +: 4] = 4'($urandom_range(0, 15));
      return b;
   endfunction

   function automatic int bmap(input int s);
      if (s == 2 || s == 5)   return -20;
      if (s == 27 || s == 28) return 10;
      if (s % 8 == 0 || s % 8 == 7 || s / 8 == 0 || s / 8 == 7) return -10;
      return 0;
   endfunction

   // Score = sum of per-square contributions, clamped to the score range after every scan group.
   function automatic int model(input int w, input logic [255:0] b);
      int lanes, hi, lo, acc, gs, s;
      logic [3:0] n;
      lanes = (w != 0) ? 8 : 1;
      hi    = (w != 0) ? 127 : 32767;
      lo    = -hi - 1;
      acc   = 0;
      for (int g = 0; g < 64 / lanes; g++) begin
         gs = 0;
         for (int l = 0; l < lanes; l++) begin
            s = g * lanes + l;
            n = b[4*s +: 4];
            if (n[2:0] >= 1 && n[2:0] <= 6) begin
               if (n[3]) gs -= tm[w][n[2:0]][s ^ 56];
               else      gs += tm[w][n[2:0]][s];
            end
         end
         acc += gs;
         if (acc > hi) acc = hi;
         if (acc < lo) acc = lo;
      end
      return acc;
   endfunction

   task automatic do_write(input int w, input int t, input int s, input int d);
      wr_type = 3'(t);
      wr_sq   = 6'(s);
      wr_data = 6'(d);
      if (w != 0) wr_en8 = 1'b1;
      else        wr_en1 = 1'b1;
      tick();
      wr_en1 = 1'b0;
      wr_en8 = 1'b0;
      if (t >= 1 && t <= 6) tm[w][t][s] = d;
   endtask

   task automatic run_scan(input int w, input logic [255:0] b, input string name);
      int n, exp, exp_cyc;
      exp     = model(w, b);
      exp_cyc = (w != 0) ? 9 : 65;
      board   = b;
      set_start(w, 1'b1);
      tick();
      set_start(w, 1'b0);
      board = {8{$urandom()}};
      n = 1;
      chk({name, "_hold"}, g_score(w), last[w]);
      while (g_done(w) == 0 && n < 200) begin
         tick();
         n++;
      end
      chk({name, "_cycle"}, n, exp_cyc);
      chk({name, "_score"}, g_score(w), exp);
      last[w] = exp;
      tick();
      chk({name, "_done_lo"}, g_done(w), 0);
      chk({name, "_busy_lo"}, g_busy(w), 0);
   endtask

   initial begin
      logic [255:0] b;
      int n, ndone, first, fscore;

      reset_n = 1'b0;
      board   = '0;
      wr_type = '0;
      wr_sq   = '0;
      wr_data = '0;
      start1  = 1'b0;
      wr_en1  = 1'b0;
      start8  = 1'b0;
      wr_en8  = 1'b0;
      last    = '{0, 0};
      for (int w = 0; w < 2; w++)
         for (int t = 0; t < 8; t++)
            for (int s = 0; s < 64; s++) tm[w][t][s] = 0;
      repeat (3) tick();
      for (int w = 0; w < 2; w++) begin
         chk("rst_busy", g_busy(w), 0);
         chk("rst_done", g_done(w), 0);
         chk("rst_score", g_score(w), 0);
      end
      reset_n = 1'b1;
      tick();

      run_scan(0, rand_board(), "zero_tbl1");
      run_scan(1, rand_board(), "zero_tbl8");

      for (int s = 0; s < 64; s++) do_write(0, 3, s, bmap(s));
      vt[0].b = '0;                                         vt[0].exp = 0;
      vt[1].b = put(put('0, 27, 4'h3), 61, 4'hB);           vt[1].exp = 30;
      vt[2].b = put('0, 0, 4'h3);                           vt[2].exp = -10;
      vt[3].b = put('0, 0, 4'hB);                           vt[3].exp = 10;
      vt[4].b = put('0, 36, 4'h3);                          vt[4].exp = 0;
      vt[5].b = put('0, 35, 4'hB);                          vt[5].exp = -10;
      vt[6].b = put('0, 27, 4'h2);                          vt[6].exp = 0;
      vt[7].b = put(put('0, 27, 4'h7), 28, 4'hF);           vt[7].exp = 0;
      vt[8].b = put(put('0, 2, 4'h3), 5, 4'h3);             vt[8].exp = -40;
      vt[9].b = put(put(put('0, 28, 4'h3), 63, 4'hB), 10, 4'h8); vt[9].exp = 20;
      for (int i = 0; i < 10; i++) begin
         run_scan(0, vt[i].b, $sformatf("vec%0d", i));
         chk($sformatf("vec%0d_table", i), g_score(0), vt[i].exp);
      end

      // start plus a write in the middle of a scan: both dropped, one done only.
      b = vt[1].b;
      board  = b;
      start1 = 1'b1;
      tick();
      start1 = 1'b0;
      n = 1; ndone = 0; first = 0; fscore = 0;
      while (n < 140) begin
         if (n == 10) begin
            start1 = 1'b1; wr_en1 = 1'b1;
            wr_type = 3'd3; wr_sq = 6'd27; wr_data = 6'h39;
         end
         tick();
         n++;
         start1 = 1'b0;
         wr_en1 = 1'b0;
         if (done1) begin
            ndone++;
            if (first == 0) begin
               first  = n;
               fscore = g_score(0);
            end
         end
      end
      chk("busy_start_ndone", ndone, 1);
      chk("busy_start_cycle", first, 65);
      chk("busy_start_score", fscore, 30);
      last[0] = 30;
      run_scan(0, b, "rescan");

      // start asserted only in the DONE cycle is ignored.
      board  = b;
      start1 = 1'b1;
      tick();
      start1 = 1'b0;
      n = 1;
      while (done1 == 1'b0 && n < 200) begin
         tick();
         n++;
      end
      chk("done_start_cycle", n, 65);
      start1 = 1'b1;
      tick();
      start1 = 1'b0;
      chk("done_start_busy", g_busy(0), 0);
      tick();
      chk("done_start_busy2", g_busy(0), 0);

      for (int s = 0; s < 64; s++) do_write(1, 1, s, 31);
      b = '0;
      for (int s = 0; s < 64; s++) b = put(b, s, 4'h1);
      run_scan(1, b, "pawn_white");
      chk("pawn_white_sat", g_score(1), 127);
      b = '0;
      for (int s = 0; s < 64; s++) b = put(b, s, 4'h9);
      run_scan(1, b, "pawn_black");
      chk("pawn_black_sat", g_score(1), -128);
      run_scan(1, '0, "empty8");
      chk("empty8_zero", g_score(1), 0);

      for (int w = 0; w < 2; w++)
         for (int t = 0; t < 8; t++)
            for (int s = 0; s < 64; s++) do_write(w, t, s, int'($urandom_range(0, 63)) - 32);
      for (int i = 0; i < 6; i++) begin
         run_scan(0, rand_board(), $sformatf("rnd1_%0d", i));
         run_scan(1, rand_board(), $sformatf("rnd8_%0d", i));
      end

      // Reset in the middle of a scan aborts it and clears tables and score.
      board  = rand_board();
      start1 = 1'b1;
      tick();
      start1 = 1'b0;
      repeat (29) tick();
      reset_n = 1'b0;
      #1;
      chk("midrst_busy", g_busy(0), 0);
      chk("midrst_done", g_done(0), 0);
      chk("midrst_score", g_score(0), 0);
      chk("midrst_score8", g_score(1), 0);
      tick();
      reset_n = 1'b1;
      for (int w = 0; w < 2; w++)
         for (int t = 0; t < 8; t++)
            for (int s = 0; s < 64; s++) tm[w][t][s] = 0;
      last = '{0, 0};
      ndone = 0;
      for (int i = 0; i < 80; i++) begin
         tick();
         if (done1) ndone++;
      end
      chk("midrst_no_done", ndone, 0);
      for (int i = 0; i < 40; i++)
         do_write(0, $urandom_range(1, 6), $urandom_range(0, 63), int'($urandom_range(0, 63)) - 32);
      run_scan(0, rand_board(), "post_rst");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
